mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_if.sv | 20 ++
 rtl/mem_wb_stage.sv | 154 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the data memory (slave).
interface mem_wb_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: issues aligned loads/stores, stalls the pipe while
// memory is busy, extends load data and flags illegal or misaligned accesses.
module mem_wb_stage (
    input  logic           clk,
    input  logic           rst_n,
    mem_wb_stage_if.master dmem,
    input  logic [31:0]    ALUResultM_i,
    input  logic [31:0]    WriteDataM_i,
    input  logic [31:0]    PCPlus4M_i,
    input  logic [4:0]     RdM_i,
    input  logic           RegWriteM_i,
    input  logic           MemWriteM_i,
    input  logic [1:0]     ResultSrcM_i,
    input  logic [2:0]     funct3M_i,
    output logic           StallM_o,
    output logic           misalign_err_o,
    output logic           RegWriteW_o,
    output logic [1:0]     ResultSrcW_o,
    output logic [4:0]     RdW_o,
    output logic [31:0]    ALUResultW_o,
    output logic [31:0]    ReadDataW_o,
    output logic [31:0]    PCPlus4W_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        isLoad, isStore, memOp, legalOp, aligned, accessOk, fault;
    logic [1:0]  byteOff;
    logic [3:0]  byteEn;
    logic [31:0] storeData, laneWord, loadData;
    logic        req, err, stall;
    logic        regWriteW_d, regWriteW_q;
    logic [4:0]  rdW_d, rdW_q;
    logic [31:0] readDataW_d, readDataW_q;
    logic [1:0]  resultSrcW_q;
    logic [31:0] aluResultW_q, pcPlus4W_q;

    always_comb begin
        isStore = MemWriteM_i;
        isLoad  = !MemWriteM_i && (ResultSrcM_i == 2'b01);
        memOp   = isStore || isLoad;
        byteOff = ALUResultM_i[1:0];
        legalOp = 1'b0;
        case (funct3M_i)
            3'b000, 3'b001, 3'b010: legalOp = 1'b1;
            3'b100, 3'b101:         legalOp = isLoad;
            default:                legalOp = 1'b0;
        endcase
        aligned = 1'b1;
        case (funct3M_i[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !byteOff[0];
            default: aligned = (byteOff == 2'b00);
        endcase
        accessOk = memOp && legalOp && aligned;
        fault    = memOp && !(legalOp && aligned);
    end

    always_comb begin
        byteEn    = 4'b1111;
        storeData = WriteDataM_i;
        if (isStore) begin
            case (funct3M_i[1:0])
                2'b00: begin
                    byteEn    = 4'b0001 << byteOff;
                    storeData = {4{WriteDataM_i[7:0]}};
                end
                2'b01: begin
                    byteEn    = 4'b0011 << byteOff;
                    storeData = {2{WriteDataM_i[15:0]}};
                end
                default: begin
                    byteEn    = 4'b1111;
                    storeData = WriteDataM_i;
                end
            endcase
        end
        laneWord = dmem.dmem_rdata >> {byteOff, 3'b000};
        case (funct3M_i)
            3'b000:  loadData = {{24{laneWord[7]}}, laneWord[7:0]};
            3'b001:  loadData = {{16{laneWord[15]}}, laneWord[15:0]};
            3'b100:  loadData = {24'd0, laneWord[7:0]};
            3'b101:  loadData = {16'd0, laneWord[15:0]};
            default: loadData = laneWord;
        endcase
    end

    // Request is decoded from the held EX/MEM inputs, so it stays stable through WAIT.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                req = accessOk;
                err = fault;
                if (accessOk && !dmem.dmem_ready) state_d = WAIT;
            end
            WAIT: begin
                req = 1'b1;
                if (dmem.dmem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            req     = 1'b0;
            err     = 1'b0;
            state_d = IDLE;
        end
        stall       = req && !dmem.dmem_ready;
        regWriteW_d = RegWriteM_i && !stall && !err;
        rdW_d       = stall ? 5'd0 : RdM_i;
        readDataW_d = isLoad ? loadData : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWriteW_q  <= 1'b0;
            resultSrcW_q <= 2'b00;
            rdW_q        <= 5'd0;
            aluResultW_q <= 32'd0;
            readDataW_q  <= 32'd0;
            pcPlus4W_q   <= 32'd0;
        end else begin
            regWriteW_q  <= regWriteW_d;
            resultSrcW_q <= ResultSrcM_i;
            rdW_q        <= rdW_d;
            aluResultW_q <= ALUResultM_i;
            readDataW_q  <= readDataW_d;
            pcPlus4W_q   <= PCPlus4M_i;
        end
    end

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = MemWriteM_i;
    assign dmem.dmem_addr  = {ALUResultM_i[31:2], 2'b00};
    assign dmem.dmem_wdata = storeData;
    assign dmem.dmem_be    = byteEn;
    assign StallM_o        = stall;
    assign misalign_err_o  = err;
    assign RegWriteW_o     = regWriteW_q;
    assign ResultSrcW_o    = resultSrcW_q;
    assign RdW_o           = rdW_q;
    assign ALUResultW_o    = aluResultW_q;
    assign ReadDataW_o     = readDataW_q;
    assign PCPlus4W_o      = pcPlus4W_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a per-cycle reference model of the memory stage
// plus hand-computed checkpoints for the key load/store/stall/reset scenarios.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] aluResultM = 32'd0, writeDataM = 32'd0, pcPlus4M = 32'd0;
    logic [4:0]  rdM = 5'd0;
    logic        regWriteM = 1'b0, memWriteM = 1'b0;
    logic [1:0]  resultSrcM = 2'd0;
    logic [2:0]  funct3M = 3'd0;
    logic        stallM, misalignErr, regWriteW;
    logic [1:0]  resultSrcW;
    logic [4:0]  rdW;
    logic [31:0] aluResultW, readDataW, pcPlus4W;

    int checkCount = 0;
    int errorCount = 0;

    mem_wb_stage_if dmemBus ();

    mem_wb_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dmem           (dmemBus),
        .ALUResultM_i   (aluResultM),
        .WriteDataM_i   (writeDataM),
        .PCPlus4M_i     (pcPlus4M),
        .RdM_i          (rdM),
        .RegWriteM_i    (regWriteM),
        .MemWriteM_i    (memWriteM),
        .ResultSrcM_i   (resultSrcM),
        .funct3M_i      (funct3M),
        .StallM_o       (stallM),
        .misalign_err_o (misalignErr),
        .RegWriteW_o    (regWriteW),
        .ResultSrcW_o   (resultSrcW),
        .RdW_o          (rdW),
        .ALUResultW_o   (aluResultW),
        .ReadDataW_o    (readDataW),
        .PCPlus4W_o     (pcPlus4W)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        stall;
        logic        err;
        logic        isLoad;
        logic [31:0] loadVal;
    } memModel_t;

    typedef struct packed {
        logic        full;
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] readData;
        logic [31:0] pc;
    } wbModel_t;

    wbModel_t expW = '0;
    wbModel_t nextW;
    memModel_t m;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // What the memory stage must do, phrased as access size, byte offset and masks.
    function automatic memModel_t modelMem(input logic memWrite, input logic [1:0] resultSrc,
                                           input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] wd, input logic [31:0] rdata,
                                           input logic ready, input logic inReset);
        memModel_t r;
        int size, offset;
        bit isStore, isLoad, legal;
        logic [31:0] mask, raw;
        r = '0;
        isStore = memWrite;
        isLoad  = !memWrite && (resultSrc == 2'b01);
        legal   = isStore ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size    = 1 << f3[1:0];
        offset  = int'(addr % 4);
        r.isLoad = isLoad;
        if (legal && size <= 4) begin
            raw  = rdata >> (8 * offset);
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            r.loadVal = raw & mask;
            if (!f3[2] && size < 4 && raw[8 * size - 1]) r.loadVal = r.loadVal | ~mask;
        end
        if (inReset || !(isStore || isLoad)) return r;
        if (legal && (addr % size) == 0) begin
            r.req  = 1'b1;
            r.addr = addr & ~32'd3;
            r.be   = isStore ? 4'(((1 << size) - 1) << offset) : 4'hF;
            for (int i = 0; i < 4; i++) r.wdata[8 * i +: 8] = wd[8 * (i % size) +: 8];
            r.stall = !ready;
        end else begin
            r.err = 1'b1;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        m = modelMem(memWriteM, resultSrcM, funct3M, aluResultM, writeDataM,
                     dmemBus.dmem_rdata, dmemBus.dmem_ready, !rst_n);
        checkOutput("cmp_req", dmemBus.dmem_req, m.req);
        checkOutput("cmp_stall", stallM, m.stall);
        checkOutput("cmp_err", misalignErr, m.err);
        if (m.req) begin
            checkOutput("cmp_we", dmemBus.dmem_we, memWriteM);
            checkOutput("cmp_addr", dmemBus.dmem_addr, m.addr);
            checkOutput("cmp_be", dmemBus.dmem_be, m.be);
            if (memWriteM) checkOutput("cmp_wdata", dmemBus.dmem_wdata, m.wdata);
        end
        if (!rst_n) expW = '{full: 1'b1, default: '0};
        checkOutput("cmp_regWriteW", regWriteW, expW.regWrite);
        checkOutput("cmp_rdW", rdW, expW.rd);
        if (expW.full || expW.regWrite) begin
            checkOutput("cmp_resultSrcW", resultSrcW, expW.resultSrc);
            checkOutput("cmp_aluResultW", aluResultW, expW.alu);
            checkOutput("cmp_readDataW", readDataW, expW.readData);
            checkOutput("cmp_pcPlus4W", pcPlus4W, expW.pc);
        end
        nextW = '0;
        if (!rst_n) begin
            nextW.full = 1'b1;
        end else if (!m.stall) begin
            nextW.regWrite  = regWriteM && !m.err;
            nextW.resultSrc = resultSrcM;
            nextW.rd        = rdM;
            nextW.alu       = aluResultM;
            nextW.pc        = pcPlus4M;
            nextW.readData  = m.isLoad ? m.loadVal : 32'd0;
        end
        expW = nextW;
    end

    task automatic applyStimulus(input logic rw, input logic mw, input logic [1:0] rs,
                                 input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc,
                                 input logic ready, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        regWriteM  = rw;
        memWriteM  = mw;
        resultSrcM = rs;
        funct3M    = f3;
        rdM        = rd;
        aluResultM = alu;
        writeDataM = wd;
        pcPlus4M   = pc;
        dmemBus.dmem_ready = ready;
        dmemBus.dmem_rdata = rdata;
    endtask

    task automatic applyNop();
        applyStimulus(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        memModel_t pin;
        rst_n = 1'b0;
        dmemBus.dmem_ready = 1'b1;
        dmemBus.dmem_rdata = 32'd0;

        pin = modelMem(1'b0, 2'b01, 3'b000, 32'h103, 32'd0, 32'h8011_2233, 1'b1, 1'b0);
        checkOutput("model_lb", pin.loadVal, 32'hFFFF_FF80);
        pin = modelMem(1'b1, 2'b00, 3'b001, 32'h102, 32'h0000_ABCD, 32'd0, 1'b0, 1'b0);
        checkOutput("model_sh_be", pin.be, 32'hC);
        checkOutput("model_sh_wdata", pin.wdata, 32'hABCD_ABCD);

        applyStimulus(1, 0, 2'b01, 3'b010, 5'd3, 32'h100, 32'd0, 32'h14, 1, 32'hDEAD_BEEF);
        #2;
        checkOutput("reset_req", dmemBus.dmem_req, 0);
        checkOutput("reset_stall", stallM, 0);
        checkOutput("reset_regWriteW", regWriteW, 0);
        checkOutput("reset_aluResultW", aluResultW, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        checkOutput("lw_req", dmemBus.dmem_req, 1);
        checkOutput("lw_stall", stallM, 0);
        checkOutput("lw_addr", dmemBus.dmem_addr, 32'h100);
        applyNop();
        #2;
        checkOutput("lw_readDataW", readDataW, 32'hDEAD_BEEF);
        checkOutput("lw_regWriteW", regWriteW, 1);
        checkOutput("lw_rdW", rdW, 3);

        applyStimulus(1, 0, 2'b01, 3'b000, 5'd4, 32'h103, 32'd0, 32'h18, 1, 32'h8011_2233);
        applyStimulus(1, 0, 2'b01, 3'b100, 5'd6, 32'h103, 32'd0, 32'h1C, 1, 32'h8011_2233);
        #2;
        checkOutput("lb_readDataW", readDataW, 32'hFFFF_FF80);
        applyStimulus(1, 0, 2'b01, 3'b001, 5'd8, 32'h102, 32'd0, 32'h20, 1, 32'h8001_1234);
        #2;
        checkOutput("lbu_readDataW", readDataW, 32'h0000_0080);
        applyStimulus(1, 0, 2'b01, 3'b101, 5'd9, 32'h102, 32'd0, 32'h24, 1, 32'h8001_1234);
        #2;
        checkOutput("lh_readDataW", readDataW, 32'hFFFF_8001);
        applyStimulus(0, 1, 2'b00, 3'b000, 5'd0, 32'h101, 32'h1234_5655, 32'h28, 1, 32'd0);
        #2;
        checkOutput("lhu_readDataW", readDataW, 32'h0000_8001);
        checkOutput("sb_be", dmemBus.dmem_be, 4'b0010);
        checkOutput("sb_wdata", dmemBus.dmem_wdata, 32'h5555_5555);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 2'b00, 3'b001, 5'd7, 32'h102, 32'h0000_ABCD, 32'h2C, 0, 32'd0);
            #2;
            checkOutput("sh_be", dmemBus.dmem_be, 4'b1100);
            checkOutput("sh_wdata", dmemBus.dmem_wdata, 32'hABCD_ABCD);
            checkOutput("sh_addr", dmemBus.dmem_addr, 32'h100);
            checkOutput("sh_stall", stallM, 1);
            if (i > 0) checkOutput("sh_bubbleRdW", rdW, 0);
        end
        applyStimulus(0, 1, 2'b00, 3'b001, 5'd7, 32'h102, 32'h0000_ABCD, 32'h2C, 1, 32'd0);
        #2;
        checkOutput("sh_done_stall", stallM, 0);
        checkOutput("sh_bubbleRdW", rdW, 0);
        checkOutput("sh_bubbleRegWriteW", regWriteW, 0);

        applyStimulus(1, 0, 2'b01, 3'b010, 5'd10, 32'h101, 32'd0, 32'h30, 1, 32'd0);
        #2;
        checkOutput("mis_req", dmemBus.dmem_req, 0);
        checkOutput("mis_err", misalignErr, 1);
        checkOutput("mis_stall", stallM, 0);
        applyNop();
        #2;
        checkOutput("mis_regWriteW", regWriteW, 0);
        checkOutput("mis_errPulse", misalignErr, 0);
        applyStimulus(1, 0, 2'b01, 3'b011, 5'd11, 32'h100, 32'd0, 32'h34, 1, 32'd0);
        applyStimulus(0, 1, 2'b00, 3'b100, 5'd0, 32'h100, 32'h1111_2222, 32'h38, 1, 32'd0);
        applyStimulus(1, 0, 2'b00, 3'b000, 5'd12, 32'h1234, 32'd0, 32'h3C, 0, 32'd0);
        applyNop();
        #2;
        checkOutput("alu_passthrough", aluResultW, 32'h1234);

        applyStimulus(0, 1, 2'b00, 3'b010, 5'd0, 32'h200, 32'hCAFE_F00D, 32'h40, 0, 32'd0);
        applyStimulus(0, 1, 2'b00, 3'b010, 5'd0, 32'h200, 32'hCAFE_F00D, 32'h40, 0, 32'd0);
        #2;
        checkOutput("sw_wait_stall", stallM, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstwait_req", dmemBus.dmem_req, 0);
        checkOutput("rstwait_stall", stallM, 0);
        checkOutput("rstwait_regWriteW", regWriteW, 0);
        checkOutput("rstwait_aluResultW", aluResultW, 0);
        applyNop();
        rst_n = 1'b1;
        applyStimulus(1, 0, 2'b01, 3'b010, 5'd13, 32'h104, 32'd0, 32'h44, 1, 32'h1122_3344);
        #2;
        checkOutput("rstwait_idleReq", dmemBus.dmem_req, 1);
        checkOutput("rstwait_idleStall", stallM, 0);

        applyStimulus(1, 0, 2'b01, 3'b010, 5'd9, 32'h300, 32'd0, 32'h48, 0, 32'd0);
        applyStimulus(1, 0, 2'b01, 3'b010, 5'd9, 32'h300, 32'd0, 32'h48, 0, 32'd0);
        #2;
        checkOutput("ldstall_bubble", regWriteW, 0);
        applyStimulus(1, 0, 2'b01, 3'b010, 5'd9, 32'h300, 32'd0, 32'h48, 1, 32'h0BAD_F00D);
        applyStimulus(1, 0, 2'b00, 3'b000, 5'd5, 32'h42, 32'd0, 32'h4C, 1, 32'd0);
        #2;
        checkOutput("ldstall_rdW", rdW, 9);
        checkOutput("ldstall_readDataW", readDataW, 32'h0BAD_F00D);
        applyNop();
        #2;
        checkOutput("alu_after_ld_rdW", rdW, 5);
        checkOutput("alu_after_ld_result", aluResultW, 32'h42);
        checkOutput("alu_after_ld_regWriteW", regWriteW, 1);
        checkOutput("alu_after_ld_readDataW", readDataW, 0);

        applyNop();
        applyNop();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
